palette_loader: RTL



---
 rtl/palette_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/palette_loader.sv
// palette_loader
//   Writer side of the video block's loadable palette RAM. Consumes the
//   byte stream of a .pal image (ENTRIES RGB triplets), packs each triplet
//   into 24 bits and issues one single-cycle write per palette entry,
//   indices 0..ENTRIES-1 in order.
//
// Ports
//   clk               system clock, all logic on posedge
//   reset             synchronous, active-high reset
//   start             single-cycle pulse, begins or restarts a load
//   byte_valid        byte_data valid this cycle
//   byte_data[7:0]    stream byte
//   byte_ready        loader accepts a byte this cycle
//   file_end          single-cycle pulse, source has sent its last byte
//   load_color        palette RAM write strobe, one cycle wide
//   load_color_index  palette entry being written
//   load_color_data   {R,G,B}
//   busy              load in progress
//   done              sticky, all entries written
//   error             sticky, short file or extra bytes after done

module palette_loader #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic             file_end,
  output logic             load_color,
  output logic [IDX_W-1:0] load_color_index,
  output logic [23:0]      load_color_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // One extra bit so the entry counter can hold ENTRIES without wrapping.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_ENTRY = CNT_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(ENTRIES);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] entry_cnt;
  logic [7:0]       red;
  logic [7:0]       green;
  logic             end_pending;
  logic             accept;

  assign accept = byte_valid & byte_ready;

  // Outputs are registered: every transition also loads the output values
  // belonging to the state being entered, so byte_ready/busy/done/error
  // always match the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      byte_cnt         <= 2'd0;
      entry_cnt        <= '0;
      red              <= 8'd0;
      green            <= 8'd0;
      end_pending      <= 1'b0;
      byte_ready       <= 1'b0;
      load_color       <= 1'b0;
      load_color_index <= '0;
      load_color_data  <= 24'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      load_color <= 1'b0;
      if (start) begin
        // start wins over a simultaneous byte and over file_end.
        state       <= RECV;
        byte_cnt    <= 2'd0;
        entry_cnt   <= '0;
        end_pending <= 1'b0;
        byte_ready  <= 1'b1;
        busy        <= 1'b1;
        done        <= 1'b0;
        error       <= 1'b0;
      end else begin
        case (state)
          RECV: begin
            if (accept) begin
              case (byte_cnt)
                2'd0: begin
                  red      <= byte_data;
                  byte_cnt <= 2'd1;
                end
                2'd1: begin
                  green    <= byte_data;
                  byte_cnt <= 2'd2;
                end
                default: begin
                  byte_cnt         <= 2'd0;
                  state            <= WRITE;
                  byte_ready       <= 1'b0;
                  load_color       <= 1'b1;
                  load_color_index <= entry_cnt[IDX_W-1:0];
                  load_color_data  <= {red, green, byte_data};
                  // Decide DONE vs ERR once the write has gone out.
                  end_pending      <= file_end;
                end
              endcase
            end
            // A file end that does not coincide with a completing byte
            // drops any partial triplet; already written entries stay.
            if (file_end && !(accept && byte_cnt == 2'd2)) begin
              state      <= ERR;
              byte_cnt   <= 2'd0;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end

          WRITE: begin
            end_pending <= 1'b0;
            if (entry_cnt != MAX_COUNT) begin
              entry_cnt <= entry_cnt + 1'b1;
            end
            if (entry_cnt == LAST_ENTRY) begin
              state      <= DONE;
              byte_ready <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else if (end_pending || file_end) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else begin
              state      <= RECV;
              byte_ready <= 1'b1;
            end
          end

          DONE: begin
            // Trailing bytes are swallowed but flagged.
            if (accept) begin
              error <= 1'b1;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
